// File: rtl/mem_arb.sv
// Two-requester memory port arbiter (IFU and LSU) with a single outstanding transaction.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise LSU has fixed priority.
module mem_arb #(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [XLEN-1:0]   ifu_req_addr,
    output logic              ifu_rsp_valid,
    output logic [XLEN-1:0]   ifu_rsp_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_wen,
    input  logic [XLEN-1:0]   lsu_req_addr,
    input  logic [STRB_W-1:0] lsu_req_wstrb,
    input  logic [XLEN-1:0]   lsu_req_wdata,
    output logic              lsu_rsp_valid,
    output logic [XLEN-1:0]   lsu_rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [STRB_W-1:0] mem_req_wstrb,
    output logic [XLEN-1:0]   mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              arb_owner,
    output logic              arb_busy,
    output logic [1:0]        arb_state
);

    // Handshake: a request transfers on a cycle where valid && ready are both high.
    // Ready is only raised in IDLE for the single winner; mem_req_* holds steady
    // from the cycle after the grant until mem_req_ready, and the response is a
    // one-cycle pulse on the owner's rsp_valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   grant_ifu, grant_lsu;
    logic   rsp_fire;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_ifu || grant_lsu) begin
            last_grant <= grant_lsu;
        end
    end
`endif

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE && !rst) begin
            if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARB_RR_EN
                grant_ifu = last_grant;
                grant_lsu = !last_grant;
`else
                grant_lsu = 1'b1;
`endif
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_ifu || grant_lsu) state_nxt = REQ;
            REQ:     if (mem_req_ready)          state_nxt = WAIT;
            WAIT:    if (mem_rsp_valid)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read payloads carry zero strobes and data so the bus never sees stale write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wstrb <= '0;
            mem_req_wdata <= '0;
            arb_owner     <= 1'b0;
        end else if (grant_lsu) begin
            mem_req_wen   <= lsu_req_wen;
            mem_req_addr  <= lsu_req_addr;
            mem_req_wstrb <= lsu_req_wen ? lsu_req_wstrb : '0;
            mem_req_wdata <= lsu_req_wen ? lsu_req_wdata : '0;
            arb_owner     <= 1'b1;
        end else if (grant_ifu) begin
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= ifu_req_addr;
            mem_req_wstrb <= '0;
            mem_req_wdata <= '0;
            arb_owner     <= 1'b0;
        end
    end

    // A response coinciding with reset is dropped along with the transaction.
    assign rsp_fire      = (state == WAIT) && mem_rsp_valid && !rst;

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign mem_req_valid = (state == REQ);
    assign arb_busy      = (state != IDLE);
    assign arb_state     = state;

    assign ifu_rsp_valid = rsp_fire && !arb_owner;
    assign ifu_rsp_rdata = ifu_rsp_valid ? mem_rsp_rdata : '0;
    assign lsu_rsp_valid = rsp_fire && arb_owner;
    assign lsu_rsp_rdata = (lsu_rsp_valid && !mem_req_wen) ? mem_rsp_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: driver tasks model the requesters and memory,
// a negedge monitor checks every response pulse against an expected queue.
module tb_mem_arb;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [3:0]  lsu_req_wstrb;
    logic [31:0] lsu_req_wdata;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        arb_owner;
    logic        arb_busy;
    logic [1:0]  arb_state;

    int n_chk  = 0;
    int n_fail = 0;

    // {owner, rdata}
    logic [32:0] exp_q[$];

    mem_arb dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_rdata (ifu_rsp_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wstrb (lsu_req_wstrb),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .arb_owner     (arb_owner),
        .arb_busy      (arb_busy),
        .arb_state     (arb_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required $finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (ifu_rsp_valid || lsu_rsp_valid) begin
            logic [32:0] got;
            logic [32:0] exp;
            got = ifu_rsp_valid ? {1'b0, ifu_rsp_rdata} : {1'b1, lsu_rsp_rdata};
            n_chk++;
            if (ifu_rsp_valid && lsu_rsp_valid) begin
                n_fail++;
                $display("FAIL rsp_both: both rsp_valid high, required one");
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got owner=%0d data=0x%08h, expected no response",
                         got[32], got[31:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL rsp_data: got owner=%0d data=0x%08h, expected owner=%0d data=0x%08h",
                             got[32], got[31:0], exp[32], exp[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Called at posedge+1 in IDLE with requester valids already driven.
    task automatic grant(input logic side);
        @(negedge clk);
        chk("ifu_req_ready", 32'(ifu_req_ready), 32'(!side));
        chk("lsu_req_ready", 32'(lsu_req_ready), 32'(side));
        tick();
        if (side) lsu_req_valid = 1'b0;
        else      ifu_req_valid = 1'b0;
    endtask

    // Called at posedge+1 in the cycle after grant; returns in IDLE.
    task automatic serve(input int delay, input logic [31:0] rdata, input logic own,
                         input logic wen, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] wdata);
        for (int i = 0; i <= delay; i++) begin
            mem_req_ready = (i == delay);
            @(negedge clk);
            chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
            chk("mem_req_addr",  mem_req_addr, addr);
            chk("mem_req_wen",   32'(mem_req_wen), 32'(wen));
            chk("mem_req_wstrb", 32'(mem_req_wstrb), 32'(strb));
            chk("mem_req_wdata", mem_req_wdata, wdata);
            chk("arb_owner",     32'(arb_owner), 32'(own));
            chk("arb_busy",      32'(arb_busy), 32'd1);
            tick();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        exp_q.push_back({own, wen ? 32'h0 : rdata});
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = 0;
        lsu_req_wstrb = 0; lsu_req_wdata = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;

        // reset state, with requests pending to confirm ready is held off
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_ifu_req_ready", 32'(ifu_req_ready), 0);
        chk("rst_lsu_req_ready", 32'(lsu_req_ready), 0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 0);
        chk("rst_mem_req_addr",  mem_req_addr, 0);
        chk("rst_arb_owner",     32'(arb_owner), 0);
        chk("rst_arb_busy",      32'(arb_busy), 0);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        do_reset();

        // IFU fetch, best-case latency
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        grant(1'b0);
        serve(0, 32'h0010_0073, 1'b0, 1'b0, 32'h8000_0000, 4'h0, 32'h0);

        // LSU write with memory stalling 3 cycles; ack data must be 0
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_1000;
        lsu_req_wstrb = 4'h3; lsu_req_wdata = 32'hDEAD_BEEF;
        grant(1'b1);
        lsu_req_wen = 1'b0; lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0;
        serve(3, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h8000_1000, 4'h3, 32'hDEAD_BEEF);

        // mem_rsp_valid while in REQ is ignored
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0200;
        grant(1'b1);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("req_rsp_ifu_valid", 32'(ifu_rsp_valid), 0);
        chk("req_rsp_lsu_valid", 32'(lsu_rsp_valid), 0);
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        @(negedge clk);
        chk("req_stays_req", 32'(arb_state), 32'd1);
        tick();
        serve(1, 32'h0000_0033, 1'b1, 1'b0, 32'h0000_0200, 4'h0, 32'h0);

        // reset during WAIT coinciding with a response
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
        grant(1'b0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_1234;
        @(negedge clk);
        chk("wrst_ifu_rsp_valid", 32'(ifu_rsp_valid), 0);
        chk("wrst_lsu_rsp_valid", 32'(lsu_rsp_valid), 0);
        tick();
        rst = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        @(negedge clk);
        chk("wrst_mem_req_valid", 32'(mem_req_valid), 0);
        chk("wrst_arb_busy",      32'(arb_busy), 0);
        chk("wrst_arb_owner",     32'(arb_owner), 0);
        chk("wrst_mem_req_addr",  mem_req_addr, 0);
        chk("wrst_ifu_rsp_valid", 32'(ifu_rsp_valid), 0);
        tick();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020;
        grant(1'b0);
        serve(0, 32'h5555_AAAA, 1'b0, 1'b0, 32'h8000_0020, 4'h0, 32'h0);

        // ties, from a fresh reset so the round-robin pointer is known
        do_reset();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h0000_0300;
`ifdef MEM_ARB_RR_EN
        grant(1'b0);
        serve(0, 32'h0000_0A01, 1'b0, 1'b0, 32'h8000_0100, 4'h0, 32'h0);
        grant(1'b1);
        serve(0, 32'h0000_0B01, 1'b1, 1'b0, 32'h0000_0300, 4'h0, 32'h0);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        grant(1'b0);
        serve(0, 32'h0000_0A02, 1'b0, 1'b0, 32'h8000_0100, 4'h0, 32'h0);
        grant(1'b1);
        serve(0, 32'h0000_0B02, 1'b1, 1'b0, 32'h0000_0300, 4'h0, 32'h0);
`else
        grant(1'b1);
        serve(0, 32'h0000_0B01, 1'b1, 1'b0, 32'h0000_0300, 4'h0, 32'h0);
        grant(1'b0);
        serve(0, 32'h0000_0A01, 1'b0, 1'b0, 32'h8000_0100, 4'h0, 32'h0);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        grant(1'b1);
        serve(0, 32'h0000_0B02, 1'b1, 1'b0, 32'h0000_0300, 4'h0, 32'h0);
        grant(1'b0);
        serve(0, 32'h0000_0A02, 1'b0, 1'b0, 32'h8000_0100, 4'h0, 32'h0);
`endif

        // back-to-back LSU reads; second grant comes one cycle after the first response
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_0100;
        @(negedge clk);
        chk("b2b_first_ready", 32'(lsu_req_ready), 1);
        tick();
        lsu_req_addr = 32'h0000_0104;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("b2b_mem_req_addr", mem_req_addr, 32'h0000_0100);
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_0011;
        exp_q.push_back({1'b1, 32'h0000_0011});
        @(negedge clk);
        chk("b2b_ready_in_rsp", 32'(lsu_req_ready), 0);
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0;
        grant(1'b1);
        serve(0, 32'h0000_0022, 1'b1, 1'b0, 32'h0000_0104, 4'h0, 32'h0);

        tick(); tick();
        chk("exp_q_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
